fetch_unit: RTL and testbench

//  Instruction fetch stage. Sits directly upstream of decode and supplies its i_instr/i_pc pair.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch buffer and the fetch_unit top.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// In-order buffer of fetched {fault, pc, instr} entries between imem and decode.
// A flush empties it in one cycle and overrides any push or pop in that cycle.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        // NOTE: every _d gets its default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; a slot is only read after being written, as tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (push_i && !flush_i && !pop_i) |-> (count_q != CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited imem requests,
// buffers in-order responses for decode and discards wrong-path responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_fault,
    input  logic        i_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    fetch_state_e     state_q, state_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic [SUM_W-1:0] credit_used;
    logic             req_valid, req_fire;
    logic             rsp_drop, fifo_push, fifo_pop;
    logic [31:0]      redirect_target;
    logic             unused_redirect_lsbs;

    // Every issued request is guaranteed a buffer slot when its response returns.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign req_valid   = !i_rst && (state_q == ST_RUN) && (credit_used < SUM_W'(FIFO_DEPTH));
    assign req_fire    = req_valid && i_imem_req_ready;

    assign rsp_drop  = i_imem_rsp_valid && (drop_cnt_q != '0);
    assign fifo_push = i_imem_rsp_valid && (drop_cnt_q == '0) && !i_redirect;
    assign fifo_pop  = o_valid && i_ready;

    assign push_entry = '{fault: i_imem_rsp_err,
                          pc:    rsp_pc_q,
                          instr: i_imem_rsp_err ? NOP_INSTR : i_imem_rsp_data};

    assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        state_d       = state_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(i_imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q - CNT_W'(rsp_drop);
        if (i_redirect) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            state_d    = ST_RUN;
            // Whatever is still in flight after this edge is wrong-path.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (fifo_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                if (i_imem_rsp_err) state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= ST_RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
        end
    end

    fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .flush_i     (i_redirect),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = fetch_pc_q;
    assign o_valid          = !fifo_empty;
    assign o_instr          = fifo_head.instr;
    assign o_pc             = fifo_head.pc;
    assign o_fault          = fifo_head.fault;

    a_rsp_has_request: assert property (@(posedge i_clk) disable iff (i_rst)
        i_imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an imem model answers one cycle after acceptance,
// expected decode entries are queued per test and a monitor checks every handshake.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        imem_rsp_err   = 1'b0;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_fault;
    logic        dec_ready      = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int unsigned  cyc = 0;
    int unsigned  hs0 = 0;
    int unsigned  hs1 = 0;
    fetch_entry_t exp_q[$];

    logic        mem_hold = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (imem_req_valid),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_req_ready (imem_req_ready),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_imem_rsp_err   (imem_rsp_err),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_valid          (dec_valid),
        .o_instr          (dec_instr),
        .o_pc             (dec_pc),
        .o_fault          (dec_fault),
        .i_ready          (dec_ready)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic fetch_entry_t exp_ok(input logic [31:0] pc);
        return '{fault: 1'b0, pc: pc, instr: ~pc};
    endfunction

    function automatic fetch_entry_t exp_flt(input logic [31:0] pc);
        return '{fault: 1'b1, pc: pc, instr: 32'h0000_0013};
    endfunction

    // Instruction memory: answers in order one cycle after acceptance; mem_hold parks responses.
    initial begin
        logic        fire_seen;
        logic [31:0] fire_addr;
        logic [31:0] a;
        logic [31:0] pend[$];
        forever begin
            @(negedge clk);
            fire_seen = !rst && imem_req_valid && imem_req_ready;
            fire_addr = imem_req_addr;
            @(posedge clk);
            #2;
            if (rst) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (fire_seen) pend.push_back(fire_addr);
                if (!mem_hold && pend.size() > 0) begin
                    a = pend.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = ~a;
                    imem_rsp_err   = (a == err_addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_err   = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every decode handshake must match the oldest expected entry.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h, expected no entry", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_entry", {dec_fault, dec_pc, dec_instr}, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic consume(input int n);
        int got = 0;
        int budget = 0;
        dec_ready = 1'b1;
        while (got < n) begin
            @(negedge clk);
            if (dec_valid) begin
                if (got == 0) hs0 = cyc;
                if (got == 1) hs1 = cyc;
                got++;
            end
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL consume_timeout: got %0d entries, expected %0d", got, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        dec_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then a free-running stream from RESET_PC.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_o_valid", dec_valid, 1'b0);
        check("reset_req_valid", imem_req_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_ok(32'(i * 4)));
        tick(1);
        consume(4);
        check("pc0_pc4_consecutive", 65'(hs1 - hs0), 65'd1);

        // Decode stalled: credit limit stops the request channel.
        tick(8);
        check("stall_req_valid", imem_req_valid, 1'b0);
        check("stall_credit_sum", 65'(dut.outstanding_q) + 65'(dut.fifo_count), 65'd2);
        check("stall_head_pc", dec_pc, 32'h10);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_ok(32'h10 + 32'(i * 4)));
        consume(4);
        tick(8);

        // Two requests in flight, then redirect to 0x100.
        mem_hold = 1'b1;
        exp_q.push_back(exp_ok(32'h20));
        exp_q.push_back(exp_ok(32'h24));
        consume(2);
        tick(6);
        check("two_outstanding", dut.outstanding_q, 2'd2);
        check("two_outstanding_req_valid", imem_req_valid, 1'b0);
        do_redirect(32'h100);
        mem_hold = 1'b0;
        @(negedge clk);
        check("redirect_drop_cnt", dut.drop_cnt_q, 2'd2);
        exp_q.push_back(exp_ok(32'h100));
        exp_q.push_back(exp_ok(32'h104));
        tick(1);
        consume(2);
        tick(8);

        // Redirect coincident with a pop and an arriving response.
        mem_hold = 1'b1;
        exp_q.push_back(exp_ok(32'h108));
        consume(1);
        tick(6);
        check("pre_redir_outstanding", dut.outstanding_q, 2'd1);
        exp_q.push_back(exp_ok(32'h10C));
        dec_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        mem_hold    = 1'b0;
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        dec_ready = 1'b0;
        @(negedge clk);
        check("pop_redir_flushed", dec_valid, 1'b0);
        check("pop_redir_drop_cnt", dut.drop_cnt_q, 2'd0);
        check("pop_redir_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
        exp_q.push_back(exp_ok(32'h200));
        exp_q.push_back(exp_ok(32'h204));
        tick(1);
        consume(2);
        tick(8);

        // Redirect coincident with an arriving response and a request fire.
        imem_req_ready = 1'b0;
        mem_hold       = 1'b1;
        exp_q.push_back(exp_ok(32'h208));
        exp_q.push_back(exp_ok(32'h20C));
        consume(2);
        tick(2);
        imem_req_ready = 1'b1;
        tick(1);
        imem_req_ready = 1'b0;
        tick(3);
        check("fire_redir_outstanding", dut.outstanding_q, 2'd1);
        check("fire_redir_pending_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h214});
        imem_req_ready = 1'b1;
        mem_hold       = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h300;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        check("fire_redir_drop_cnt", dut.drop_cnt_q, 2'd1);
        check("fire_redir_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h300});
        exp_q.push_back(exp_ok(32'h300));
        exp_q.push_back(exp_ok(32'h304));
        tick(1);
        consume(2);
        tick(8);

        // Access fault at 0x8 halts fetch until a redirect.
        err_addr = 32'h8;
        do_redirect(32'h0);
        exp_q.push_back(exp_ok(32'h0));
        exp_q.push_back(exp_ok(32'h4));
        exp_q.push_back(exp_flt(32'h8));
        exp_q.push_back(exp_ok(32'hC));
        tick(6);
        consume(4);
        tick(6);
        check("halt_req_valid", imem_req_valid, 1'b0);
        check("halt_o_valid", dec_valid, 1'b0);
        check("halt_state", dut.state_q == ST_HALT, 1'b1);
        err_addr = 32'hFFFF_FFFF;
        do_redirect(32'h40);
        @(negedge clk);
        check("halt_exit_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h40});
        exp_q.push_back(exp_ok(32'h40));
        exp_q.push_back(exp_ok(32'h44));
        tick(1);
        consume(2);
        tick(8);

        // Unaligned redirect target and PC wrap-around.
        do_redirect(32'h103);
        @(negedge clk);
        check("unaligned_redirect_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
        exp_q.push_back(exp_ok(32'h100));
        tick(1);
        consume(1);
        tick(8);
        do_redirect(32'hFFFF_FFF8);
        exp_q.push_back(exp_ok(32'hFFFF_FFF8));
        exp_q.push_back(exp_ok(32'hFFFF_FFFC));
        exp_q.push_back(exp_ok(32'h0));
        exp_q.push_back(exp_ok(32'h4));
        consume(4);
        tick(8);

        // Asynchronous reset in the middle of a stream.
        check("pre_reset_o_valid", dec_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_o_valid", dec_valid, 1'b0);
        check("async_reset_req_valid", imem_req_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("restart_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        exp_q.push_back(exp_ok(32'h0));
        exp_q.push_back(exp_ok(32'h4));
        tick(1);
        consume(2);
        tick(4);

        check("scoreboard_drained", 65'(exp_q.size()), 65'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
